spi_luks_target: RTL and testbench

SPI mode-0 responder (target) in the system clock domain: the far end of the SPI master that drives SCLK, Luks SS and MOSI on the uio pins. Oversamples SCLK/SS/MOSI, deserialises MOSI bytes MSB-first and serialises a queued response byte on MISO. Serves as the on-chip Luks peripheral model and the loopback target for bring-up.

---
 rtl/spi_luks_target_if.sv | 27 ++
 rtl/spi_luks_target.sv | 162 ++++++++++++++++
 tb/tb_spi_luks_target.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_luks_target_if.sv
// Bundles the SPI pins and the byte-level RX/TX handshake of spi_luks_target.
// slave: the target's view. master: the view of the SPI master plus the byte client.
interface spi_luks_target_if;
  logic       spi_sclk;
  logic       spi_ss_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_abort;
  logic       tx_underrun;

  modport slave (
    input  spi_sclk, spi_ss_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, frame_abort, tx_underrun
  );

  modport master (
    output spi_sclk, spi_ss_n, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, frame_abort, tx_underrun
  );
endinterface

// File: rtl/spi_luks_target.sv
// SPI mode-0 target in the clk domain. SCLK/SS/MOSI are oversampled, MOSI bytes are
// deserialised MSB-first and a queued response byte is shifted out on MISO.
// Build option: SPI_LUKS_LOOPBACK_EN -- an empty holding register at a byte start sends the
// last received byte instead of TX_IDLE.
module spi_luks_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  spi_luks_target_if.slave  bus_io
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_shift_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic [7:0] tx_shift_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       miso_q, oe_q, busy_q, abort_q, underrun_q;

  logic       tx_accept;
  logic [7:0] fill_byte;
  logic [7:0] ld_byte;
  logic       ld_empty;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  assign tx_accept = bus_io.tx_valid & ~hold_full_q;

`ifdef SPI_LUKS_LOOPBACK_EN
  assign fill_byte = rx_data_q;
`else
  assign fill_byte = TX_IDLE;
`endif

  // Byte for a frame/byte start: holding register, else a same-cycle write, else the filler.
  always_comb begin
    ld_byte  = fill_byte;
    ld_empty = 1'b1;
    if (hold_full_q) begin
      ld_byte  = hold_q;
      ld_empty = 1'b0;
    end else if (tx_accept) begin
      ld_byte  = bus_io.tx_data;
      ld_empty = 1'b0;
    end
  end

  // Synchronisers plus edge-detect registers. SS resets low so a select still held
  // across reset produces no falling edge: the master must re-assert it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus_io.spi_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus_io.spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_io.spi_mosi};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  // Frame FSM with holding register, shifters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      if (tx_accept) begin
        hold_q      <= bus_io.tx_data;
        hold_full_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q     <= StActive;
            bit_cnt_q   <= 3'd0;
            oe_q        <= 1'b1;
            busy_q      <= 1'b1;
            tx_shift_q  <= ld_byte;
            miso_q      <= ld_byte[7];
            hold_full_q <= 1'b0;
            underrun_q  <= ld_empty;
          end
        end
        StActive: begin
          if (ss_rise) begin
            // Release wins over any coincident SCLK edge; the holding register survives.
            state_q   <= StIdle;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            abort_q   <= (bit_cnt_q != 3'd0);
            bit_cnt_q <= 3'd0;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[5:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= {rx_shift_q, mosi_s};
              rx_valid_q <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt_q != 3'd0) begin
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              miso_q     <= tx_shift_q[6];
            end else begin
              // Byte boundary: next response byte.
              tx_shift_q  <= ld_byte;
              miso_q      <= ld_byte[7];
              hold_full_q <= 1'b0;
              if (ld_empty) underrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.spi_miso    = miso_q;
  assign bus_io.spi_miso_oe = oe_q;
  assign bus_io.rx_data     = rx_data_q;
  assign bus_io.rx_valid    = rx_valid_q;
  assign bus_io.tx_ready    = ~hold_full_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.frame_abort = abort_q;
  assign bus_io.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_luks_target.sv
// Directed bench for spi_luks_target: a bit-banged SPI master at clk/10, a byte-level
// model of the response queue and received bytes, and a per-cycle RX/abort monitor.
module tb_spi_luks_target;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_luks_target_if bus ();

  spi_luks_target #(
    .SYNC_STAGES(2),
    .TX_IDLE    (8'hFF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_tests = 0;
  int n_fail = 0;
  int abort_seen = 0;

  // Byte-level model state.
  logic [7:0] exp_rx[$];
  logic       m_hold_full;
  logic [7:0] m_hold;
  logic [7:0] m_last_rx;
  logic       m_underrun;
  logic [7:0] f_mosi[3];
  logic [7:0] f_miso[3];
  logic [7:0] exp_miso[3];
  logic [7:0] cmp_e;

`ifdef SPI_LUKS_LOOPBACK_EN
  localparam logic [7:0] T1Miso = 8'h00;
  localparam logic [7:0] T2Miso1 = 8'h12;
`else
  localparam logic [7:0] T1Miso = 8'hFF;
  localparam logic [7:0] T2Miso1 = 8'hFF;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_hold_full = 1'b0;
    m_hold      = 8'h00;
    m_last_rx   = 8'h00;
    m_underrun  = 1'b0;
    exp_rx.delete();
  endtask

  // Byte the target must send at a byte start.
  task automatic model_take(output logic [7:0] b);
    if (m_hold_full) begin
      b = m_hold;
      m_hold_full = 1'b0;
    end else begin
`ifdef SPI_LUKS_LOOPBACK_EN
      b = m_last_rx;
`else
      b = 8'hFF;
`endif
      m_underrun = 1'b1;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    m_hold       = d;
    m_hold_full  = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic sclk_bit(input logic v);
    bus.spi_mosi = v;
    tick(5);
    bus.spi_sclk = 1'b1;
    tick(5);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", bus.spi_miso, 0);
    check("rst_oe", bus.spi_miso_oe, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_abort", bus.frame_abort, 0);
    check("rst_tx_underrun", bus.tx_underrun, 0);
  endtask

  // One SS-low frame of nbytes; partial>0 cuts the last byte after that many bits.
  // bw_idx selects the byte whose final SCLK fall coincides with a tx write of bw_data.
  task automatic run_frame(input int nbytes, input int partial, input int bw_idx,
                           input logic [7:0] bw_data);
    logic [7:0] got;
    int nb;
    abort_seen    = 0;
    bus.spi_ss_n  = 1'b0;
    m_underrun    = 1'b0;
    model_take(exp_miso[0]);
    tick(6);
    check("busy_in_frame", bus.busy, 1);
    check("oe_in_frame", bus.spi_miso_oe, 1);
    check("tx_ready_after_start", bus.tx_ready, !m_hold_full);
    for (int b = 0; b < nbytes; b++) begin
      nb  = (b == nbytes - 1 && partial != 0) ? partial : 8;
      got = 8'h00;
      if (nb == 8) exp_rx.push_back(f_mosi[b]);
      for (int i = 0; i < nb; i++) begin
        bus.spi_mosi = f_mosi[b][7-i];
        tick(5);
        got[7-i] = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        tick(5);
        bus.spi_sclk = 1'b0;
        if (i == 7) begin
          m_last_rx = f_mosi[b];
          if (b == bw_idx) begin
            // Write lands on the same clock the target acts on this fall.
            tick(2);
            bus.tx_data  = bw_data;
            bus.tx_valid = 1'b1;
            m_hold       = bw_data;
            m_hold_full  = 1'b1;
            tick(1);
            bus.tx_valid = 1'b0;
          end
          model_take(exp_miso[b+1]);
        end
      end
      f_miso[b] = got;
      if (nb == 8) check("miso_byte", got, exp_miso[b]);
    end
    tick(5);
    bus.spi_ss_n = 1'b1;
    tick(3);
    check("busy_after_release", bus.busy, 0);
    check("oe_after_release", bus.spi_miso_oe, 0);
    tick(3);
    check("frame_abort_count", abort_seen, (partial != 0) ? 1 : 0);
    check("rx_bytes_outstanding", exp_rx.size(), 0);
    check("tx_underrun", bus.tx_underrun, m_underrun);
  endtask

  // Every rx_valid must match the next expected byte; count frame_abort pulses.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got rx_valid with rx_data %0h, required no rx_valid",
                   bus.rx_data);
        end else begin
          cmp_e = exp_rx.pop_front();
          check("rx_data", bus.rx_data, cmp_e);
        end
      end
      if (bus.frame_abort) abort_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.spi_sclk = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    tick(3);
    check_reset_outputs();
    rst = 1'b0;
    tick(4);
    check("idle_busy", bus.busy, 0);

    // Single byte, nothing queued.
    f_mosi[0] = 8'hA5;
    run_frame(1, 0, -1, 8'h00);
    check("t1_miso_literal", f_miso[0], T1Miso);
    check("t1_rx_data", bus.rx_data, 8'hA5);
    check("t1_underrun", bus.tx_underrun, 1);

    // Queued response, two-byte frame.
    tx_write(8'h3C);
    check("t2_tx_ready_low", bus.tx_ready, 0);
    f_mosi[0] = 8'h12;
    f_mosi[1] = 8'h34;
    run_frame(2, 0, -1, 8'h00);
    check("t2_miso0_literal", f_miso[0], 8'h3C);
    check("t2_miso1_literal", f_miso[1], T2Miso1);
    check("t2_rx_data", bus.rx_data, 8'h34);

    // Abort after 5 bits, then a clean frame.
    f_mosi[0] = 8'hC3;
    run_frame(1, 5, -1, 8'h00);
    check("t3_rx_data_kept", bus.rx_data, 8'h34);
    f_mosi[0] = 8'h81;
    run_frame(1, 0, -1, 8'h00);
    check("t3_rx_data", bus.rx_data, 8'h81);

    // Write coinciding with the byte-boundary fall.
    f_mosi[0] = 8'h0F;
    f_mosi[1] = 8'hF0;
    run_frame(2, 0, 0, 8'h5A);
    check("t4_miso1_literal", f_miso[1], 8'h5A);

    // Reset mid-byte.
    bus.spi_ss_n = 1'b0;
    tick(6);
    sclk_bit(1'b1);
    sclk_bit(1'b0);
    sclk_bit(1'b1);
    rst = 1'b1;
    tick(1);
    check_reset_outputs();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) sclk_bit(1'b1);
    check("t5_no_resume_busy", bus.busy, 0);
    check("t5_no_resume_oe", bus.spi_miso_oe, 0);
    bus.spi_ss_n = 1'b1;
    tick(6);
    for (int i = 0; i < 8; i++) sclk_bit(i[0]);
    tick(6);
    check("t5_ss_high_busy", bus.busy, 0);
    check("t5_ss_high_rx_data", bus.rx_data, 0);

`ifdef SPI_LUKS_LOOPBACK_EN
    // Loopback fill with an empty holding register.
    f_mosi[0] = 8'h77;
    f_mosi[1] = 8'h00;
    run_frame(2, 0, -1, 8'h00);
    check("t6_miso0_literal", f_miso[0], 8'h00);
    check("t6_miso1_literal", f_miso[1], 8'h77);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
